// File: rtl/sample_fifo.sv
// First-word-fall-through sample buffer between a filter and a downstream consumer.
// Upstream cannot be stalled, so samples that find the buffer full are dropped and flagged.
module sample_fifo #(
    parameter int data_width = 16,
    parameter int depth      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic [data_width-1:0]    data_in,
    input  logic                     ready_in,
    input  logic                     overflow_clr,
    output logic                     valid_out,
    output logic [data_width-1:0]    data_out,
    output logic [$clog2(depth):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [data_width-1:0] mem [depth];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          pop, push, drop;

    assign full  = (count_q == CW'(depth));
    assign empty = (count_q == '0);

    always_comb begin
        pop        = !empty && ready_in;
        push       = valid_in && (!full || pop);
        drop       = valid_in && !push;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        // depth is a power of two, so the natural pointer rollover is the modulo
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        if (push)
            wr_ptr_d = wr_ptr_q + AW'(1);
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);

        // a drop in the same cycle as a clear keeps the flag set
        if (drop)
            overflow_d = 1'b1;
        else if (overflow_clr)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is left unreset; stale contents never reach data_out while empty
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= data_in;
    end

    assign valid_out = !empty;
    assign data_out  = valid_out ? mem[rd_ptr_q] : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sample_fifo.sv
// Randomized and directed checks of sample_fifo against a queue-based reference model.
module tb_sample_fifo;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          ready_in;
    logic          overflow_clr;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [3:0]    count;
    logic          full;
    logic          empty;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq[$];
    logic          m_ovf = 1'b0;

    sample_fifo #(.data_width(DW), .depth(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .ready_in     (ready_in),
        .overflow_clr (overflow_clr),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [DW-1:0] exp_d;
        exp_d = (mq.size() != 0) ? mq[0] : '0;
        chk("count", 32'(count), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("valid_out", 32'(valid_out), 32'(mq.size() != 0));
        chk("data_out", 32'(data_out), 32'(exp_d));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // One clock: apply inputs, advance the model with the spec rules, compare after the edge
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
        bit do_pop, do_push;
        valid_in     = v;
        data_in      = d;
        ready_in     = r;
        overflow_clr = c;
        do_pop  = (mq.size() != 0) && r;
        do_push = v && ((mq.size() < DEPTH) || do_pop);
        @(posedge clk);
        if (do_pop)
            void'(mq.pop_front());
        if (do_push)
            mq.push_back(d);
        if (v && !do_push)
            m_ovf = 1'b1;
        else if (c)
            m_ovf = 1'b0;
        #1;
        check_model();
        $display("txn v=%0d d=0x%04h r=%0d clr=%0d -> count=%0d dout=0x%04h vout=%0d ovf=%0d",
                 v, d, r, c, count, data_out, valid_out, overflow);
    endtask

    initial begin
        rst_n        = 1'b0;
        valid_in     = 1'b0;
        data_in      = '0;
        ready_in     = 1'b0;
        overflow_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_model();
        // release between edges with ready_in low
        rst_n = 1'b1;
        step(0, 16'h0000, 0, 0);
        chk("rst_data_out", 32'(data_out), 32'h0);

        // three pushes with consumer stalled, then drain in order
        step(1, 16'h1000, 0, 0);
        chk("fwft_first", 32'(data_out), 32'h1000);
        step(1, 16'h2000, 0, 0);
        step(1, 16'hE000, 0, 0);
        chk("three_count", 32'(count), 32'd3);
        for (int i = 0; i < 4; i++) step(0, 16'h0000, 1, 0);
        chk("drained_empty", 32'(empty), 32'd1);

        // ten pushes into eight slots
        for (int i = 1; i <= 10; i++) begin
            step(1, 16'(i), 0, 0);
            if (i == 8) begin
                chk("fill_full", 32'(full), 32'd1);
                chk("fill_count", 32'(count), 32'd8);
            end
        end
        chk("drop_overflow", 32'(overflow), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", 32'(data_out), 32'(i));
            step(0, 16'h0000, 1, 0);
        end

        // full with simultaneous push and pop across pointer wrap
        step(0, 16'h0000, 0, 1);
        chk("clr_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) step(1, 16'(16'h0100 + i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 16'(16'h0200 + i), 1, 0);
            chk("stream_count", 32'(count), 32'd8);
        end
        chk("stream_no_ovf", 32'(overflow), 32'd0);

        // clear racing a drop, then a clean clear
        step(1, 16'h7FFF, 0, 0);
        chk("ovf_set", 32'(overflow), 32'd1);
        step(1, 16'h8000, 0, 1);
        chk("drop_beats_clr", 32'(overflow), 32'd1);
        step(0, 16'h0000, 0, 1);
        chk("clr_no_drop", 32'(overflow), 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0));

        // bring occupancy to exactly five, then reset between edges
        while (mq.size() > 5) step(0, 16'h0000, 1, 0);
        while (mq.size() < 5) step(1, 16'($urandom), 0, 0);
        chk("pre_reset_count", 32'(count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid_out", 32'(valid_out), 32'd0);
        chk("async_data_out", 32'(data_out), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        chk("async_overflow", 32'(overflow), 32'd0);
        mq.delete();
        m_ovf = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(1, 16'hABCD, 0, 0);
        chk("first_after_reset", 32'(data_out), 32'hABCD);
        step(0, 16'h0000, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
